// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_timing_gen_if : raster timing bundle (timing source to display) |
// | Optional: VGA_FRAME_COUNT_EN adds frame_count.      Revision: 1.0   |
// +--------------------------------------------------------------------+
interface vga_timing_gen_if;
  logic       pix_en;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       sync;
  logic       frame_start;
  logic       hs_d;
  logic       vs_d;
  logic       blank_d;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  modport master (
    output pix_en, DrawX, DrawY, blank, hs, vs, sync, frame_start,
    output hs_d, vs_d, blank_d
`ifdef VGA_FRAME_COUNT_EN
    , output frame_count
`endif
  );

  modport slave (
    input pix_en, DrawX, DrawY, blank, hs, vs, sync, frame_start,
    input hs_d, vs_d, blank_d
`ifdef VGA_FRAME_COUNT_EN
    , input frame_count
`endif
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_timing_gen : VGA raster counters, syncs and pixel-delayed copies |
// | Optional: VGA_FRAME_COUNT_EN adds frame_count.      Revision: 1.0   |
// +--------------------------------------------------------------------+
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DELAY = 2
) (
  input  logic             vga_clk,
  input  logic             Reset,
  vga_timing_gen_if.master vga_o
);
  localparam int              c_div_w    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [9:0] c_h_last   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] c_v_last   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] c_h_vis    = 10'(H_VISIBLE);
  localparam logic [9:0] c_v_vis    = 10'(V_VISIBLE);
  localparam logic [9:0] c_hs_start = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] c_hs_end   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] c_vs_start = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] c_vs_end   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [c_div_w-1:0] div_q, div_d;
  logic [9:0]         hc_q, hc_d;
  logic [9:0]         vc_q, vc_d;
  logic               vis_q, vis_d;
  logic               hsn_q, hsn_d;
  logic               vsn_q, vsn_d;
  logic               fs_q, fs_d;
  logic               w_pix_en;

  assign w_pix_en = (div_q == c_div_last);

  // Decodes use the next counter values so the registered copies line up
  // with the registered counters in the same cycle.
  always_comb begin
    div_d = (div_q == c_div_last) ? '0 : div_q + 1'b1;
    hc_d  = hc_q;
    vc_d  = vc_q;
    fs_d  = 1'b0;
    if (w_pix_en) begin
      if (hc_q == c_h_last) begin
        hc_d = '0;
        if (vc_q == c_v_last) begin
          vc_d = '0;
          fs_d = 1'b1;
        end else begin
          vc_d = vc_q + 1'b1;
        end
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end
    vis_d = (hc_d < c_h_vis) && (vc_d < c_v_vis);
    hsn_d = !((hc_d >= c_hs_start) && (hc_d < c_hs_end));
    vsn_d = !((vc_d >= c_vs_start) && (vc_d < c_vs_end));
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      div_q <= '0;
      hc_q  <= '0;
      vc_q  <= '0;
      vis_q <= 1'b1;
      hsn_q <= 1'b1;
      vsn_q <= 1'b1;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      hc_q  <= hc_d;
      vc_q  <= vc_d;
      vis_q <= vis_d;
      hsn_q <= hsn_d;
      vsn_q <= vsn_d;
      fs_q  <= fs_d;
    end
  end

  generate
    if (PIPE_DELAY == 0) begin : g_no_delay
      assign vga_o.hs_d    = hsn_q;
      assign vga_o.vs_d    = vsn_q;
      assign vga_o.blank_d = vis_q;
    end else begin : g_delay
      // Each stage holds {hs, vs, blank} of one earlier pixel.
      logic [2:0] dly_q [PIPE_DELAY];

      always_ff @(posedge vga_clk) begin
        if (Reset) begin
          for (int i = 0; i < PIPE_DELAY; i++) begin
            dly_q[i] <= 3'b110;
          end
        end else if (w_pix_en) begin
          dly_q[0] <= {hsn_q, vsn_q, vis_q};
          for (int i = 1; i < PIPE_DELAY; i++) begin
            dly_q[i] <= dly_q[i-1];
          end
        end
      end

      assign vga_o.hs_d    = dly_q[PIPE_DELAY-1][2];
      assign vga_o.vs_d    = dly_q[PIPE_DELAY-1][1];
      assign vga_o.blank_d = dly_q[PIPE_DELAY-1][0];
    end
  endgenerate

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] fcnt_q;

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      fcnt_q <= '0;
    end else if (fs_d) begin
      fcnt_q <= fcnt_q + 1'b1;
    end
  end

  assign vga_o.frame_count = fcnt_q;
`endif

  assign vga_o.pix_en      = w_pix_en;
  assign vga_o.DrawX       = hc_q;
  assign vga_o.DrawY       = vc_q;
  assign vga_o.blank       = vis_q;
  assign vga_o.hs          = hsn_q;
  assign vga_o.vs          = vsn_q;
  assign vga_o.sync        = 1'b0;
  assign vga_o.frame_start = fs_q;
endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_vga_timing_gen : directed table + sequence bench for the raster  |
// | Instance A: 800-pixel lines, 10-line frames. Instance B: tiny, /1.  |
// +--------------------------------------------------------------------+
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if ifa();
  vga_timing_gen_if ifb();

  vga_timing_gen #(
    .H_VISIBLE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_VISIBLE(4), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .CLK_DIV(2), .PIPE_DELAY(2)
  ) dut_a (.vga_clk(clk), .Reset(rst), .vga_o(ifa));

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .CLK_DIV(1), .PIPE_DELAY(0)
  ) dut_b (.vga_clk(clk), .Reset(rst), .vga_o(ifb));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // fl = {pix_en, blank, hs, vs, frame_start, blank_d, hs_d}
  typedef struct {
    int         at;
    int         x;
    int         y;
    logic [6:0] fl;
  } vec_t;

  vec_t tbl [23];

  function automatic logic [6:0] flags_a();
    return {ifa.pix_en, ifa.blank, ifa.hs, ifa.vs, ifa.frame_start, ifa.blank_d, ifa.hs_d};
  endfunction

  // Instance B monitor: strobe always on, no delay, one pixel per cycle.
  bit   b_armed = 1'b0;
  bit   b_prev_ok = 1'b0;
  logic b_prev_rst = 1'b1;
  int   b_err = 0;
  int   b_fs = 0;
  int   bpx = 0, bpy = 0, bex = 0, bey = 0;

  always @(negedge clk) begin
    if (b_armed) begin
      if (ifb.pix_en !== 1'b1) b_err++;
      if (ifb.hs_d !== ifb.hs || ifb.vs_d !== ifb.vs || ifb.blank_d !== ifb.blank) b_err++;
      if (b_prev_ok) begin
        if (b_prev_rst) begin
          bex = 0;
          bey = 0;
          if (ifb.frame_start !== 1'b0) b_err++;
        end else begin
          bex = (bpx == 15) ? 0 : bpx + 1;
          bey = (bpx == 15) ? ((bpy == 7) ? 0 : bpy + 1) : bpy;
          if (ifb.frame_start !== ((bpx == 15) && (bpy == 7))) b_err++;
          if (ifb.frame_start === 1'b1) b_fs++;
        end
        if (int'(ifb.DrawX) != bex || int'(ifb.DrawY) != bey) b_err++;
      end
      bpx        = int'(ifb.DrawX);
      bpy        = int'(ifb.DrawY);
      b_prev_rst = rst;
      b_prev_ok  = 1'b1;
    end
  end

  initial begin
    #1200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int x, y, px, py, exp_x, exp_y, bud;
    logic pe, ppe, bl, hs, vs, fs;
    int bl_cnt, vs_cnt, hs_cnt, hs_first, fs_cnt, fs_n, dly_err, cnt_err, dec_err;
    logic [2:0] hist [$];

    tbl[0]  = '{1,     0,   0, 7'b1111001};
    tbl[1]  = '{2,     1,   0, 7'b0111001};
    tbl[2]  = '{4,     2,   0, 7'b0111011};
    tbl[3]  = '{1279,  639, 0, 7'b1111011};
    tbl[4]  = '{1280,  640, 0, 7'b0011011};
    tbl[5]  = '{1311,  655, 0, 7'b1011001};
    tbl[6]  = '{1312,  656, 0, 7'b0001001};
    tbl[7]  = '{1316,  658, 0, 7'b0001000};
    tbl[8]  = '{1503,  751, 0, 7'b1001000};
    tbl[9]  = '{1504,  752, 0, 7'b0011000};
    tbl[10] = '{1508,  754, 0, 7'b0011001};
    tbl[11] = '{1599,  799, 0, 7'b1011001};
    tbl[12] = '{1600,  0,   1, 7'b0111001};
    tbl[13] = '{1604,  2,   1, 7'b0111011};
    tbl[14] = '{6400,  0,   4, 7'b0011001};
    tbl[15] = '{9599,  799, 5, 7'b1011001};
    tbl[16] = '{9600,  0,   6, 7'b0010001};
    tbl[17] = '{12799, 799, 7, 7'b1010001};
    tbl[18] = '{12800, 0,   8, 7'b0011001};
    tbl[19] = '{15999, 799, 9, 7'b1011001};
    tbl[20] = '{16000, 0,   0, 7'b0111101};
    tbl[21] = '{16001, 0,   0, 7'b1111001};
    tbl[22] = '{16002, 1,   0, 7'b0111001};

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_x", ifa.DrawX, 0);
    check("rst_y", ifa.DrawY, 0);
    check("rst_flags", flags_a(), 7'b0111001);
    check("rst_vs_d", ifa.vs_d, 1);
    check("rst_sync", ifa.sync, 0);
`ifdef VGA_FRAME_COUNT_EN
    check("rst_fcount", ifa.frame_count, 0);
`endif
    b_armed = 1'b1;
    rst = 1'b0;
    n = 0;

    foreach (tbl[i]) begin
      while (n < tbl[i].at) begin
        tick();
        n++;
      end
      check($sformatf("vec%0d_x", i), ifa.DrawX, tbl[i].x);
      check($sformatf("vec%0d_y", i), ifa.DrawY, tbl[i].y);
      check($sformatf("vec%0d_flags", i), flags_a(), tbl[i].fl);
    end

    // One full frame of cycles, starting mid-line 0
    bl_cnt = 0; vs_cnt = 0; hs_cnt = 0; hs_first = -1; fs_cnt = 0; fs_n = -1;
    dly_err = 0; cnt_err = 0; dec_err = 0;
    px = int'(ifa.DrawX); py = int'(ifa.DrawY); ppe = ifa.pix_en;
    for (int k = 0; k < 16000; k++) begin
      tick();
      n++;
      x = int'(ifa.DrawX); y = int'(ifa.DrawY);
      pe = ifa.pix_en; bl = ifa.blank; hs = ifa.hs; vs = ifa.vs; fs = ifa.frame_start;
      exp_x = ppe ? ((px == 799) ? 0 : px + 1) : px;
      exp_y = (ppe && px == 799) ? ((py == 9) ? 0 : py + 1) : py;
      if (x != exp_x || y != exp_y || pe === ppe) cnt_err++;
      if (fs !== (ppe && px == 799 && py == 9)) cnt_err++;
      if (bl !== ((x < 640) && (y < 4))) dec_err++;
      if (hs !== !((x >= 656) && (x < 752))) dec_err++;
      if (vs !== !((y == 6) || (y == 7))) dec_err++;
      if (pe) begin
        if (bl) bl_cnt++;
        if (!vs) vs_cnt++;
        if (y == 2 && !hs) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = x;
        end
        hist.push_back({hs, vs, bl});
        if (hist.size() >= 3 && {ifa.hs_d, ifa.vs_d, ifa.blank_d} !== hist[hist.size()-3]) dly_err++;
      end
      if (fs) begin
        fs_cnt++;
        fs_n = n;
      end
      px = x; py = y; ppe = pe;
    end
    check("frame_blank_pixels", bl_cnt, 2560);
    check("frame_vs_low_strobes", vs_cnt, 1600);
    check("line_hs_low_strobes", hs_cnt, 96);
    check("line_hs_first_x", hs_first, 656);
    check("frame_fs_count", fs_cnt, 1);
    check("frame_fs_interval", fs_n - 16000, 16000);
    check("delay_line_errors", dly_err, 0);
    check("counter_errors", cnt_err, 0);
    check("decode_errors", dec_err, 0);
`ifdef VGA_FRAME_COUNT_EN
    check("fcount_two_frames", ifa.frame_count, 2);
`endif

    // Mid-frame reset inside both sync pulses
    bud = 0;
    while (!(ifa.DrawX == 10'd700 && ifa.DrawY == 10'd7) && bud < 20000) begin
      tick();
      bud++;
    end
    check("reach_700_7", bud < 20000, 1);
    check("pre_rst_hs", ifa.hs, 0);
    check("pre_rst_vs", ifa.vs, 0);
    rst = 1'b1;
    tick();
    check("mid_rst_x", ifa.DrawX, 0);
    check("mid_rst_y", ifa.DrawY, 0);
    check("mid_rst_flags", flags_a(), 7'b0111001);
    check("mid_rst_vs_d", ifa.vs_d, 1);
`ifdef VGA_FRAME_COUNT_EN
    check("mid_rst_fcount", ifa.frame_count, 0);
`endif
    rst = 1'b0;
    n = 0;
    repeat (3) begin
      tick();
      n++;
    end
    check("restart_x", ifa.DrawX, 1);
    check("restart_y", ifa.DrawY, 0);
    while (ifa.frame_start !== 1'b1 && n < 20000) begin
      tick();
      n++;
    end
    check("restart_fs_at", n, 16000);
    check("restart_fs_xy", {ifa.DrawX, ifa.DrawY}, 20'd0);
`ifdef VGA_FRAME_COUNT_EN
    check("restart_fcount", ifa.frame_count, 1);
`endif
    tick();
    check("restart_fs_one_cycle", ifa.frame_start, 0);

    check("b_errors", b_err, 0);
    check("b_frames_seen", b_fs > 100, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
